// File: rtl/spi_reg_ctrl_if.sv
// SPI-byte / register-bus signal bundle for spi_reg_ctrl.
// The master modport is the controller's view and the slave modport is the surrounding logic's view.
// Pure wiring, no latency and no flow control of its own.
interface spi_reg_ctrl_if;
  logic       i_spi_cs_b;
  logic       i_rx_data_valid;
  logic [7:0] i_rx_byte;
  logic       o_tx_data_valid;
  logic [7:0] o_tx_byte;
  logic [1:0] o_mod_sel;
  logic [4:0] o_ioc;
  logic       o_wr_stb;
  logic [7:0] o_wr_data;
  logic       o_rd_stb;
  logic       i_rd_valid;
  logic [7:0] i_rd_data;
  logic [7:0] o_err_cnt;

  modport master (
    input  i_spi_cs_b, i_rx_data_valid, i_rx_byte, i_rd_valid, i_rd_data,
    output o_tx_data_valid, o_tx_byte, o_mod_sel, o_ioc, o_wr_stb,
    o_wr_data, o_rd_stb, o_err_cnt
  );

  modport slave (
    output i_spi_cs_b, i_rx_data_valid, i_rx_byte, i_rd_valid, i_rd_data,
    input  o_tx_data_valid, o_tx_byte, o_mod_sel, o_ioc, o_wr_stb,
    o_wr_data, o_rd_stb, o_err_cnt
  );
endinterface

// File: rtl/spi_reg_ctrl.sv
// SPI frame parser: command byte then data bytes, issuing register write/read strobes and tx reloads.
// Every output is registered one cycle after its cause; CS deassertion acts 2 cycles after the raw edge.
// No backpressure: rx bytes are pulses, read data is awaited up to RD_TIMEOUT cycles then answered with 0xEE.
// Build option SPI_CTRL_BURST_EN: multi-byte bursts with auto-incrementing register address.
module spi_reg_ctrl #(
  parameter int unsigned RD_TIMEOUT = 15
) (
  input logic            i_sys_clk,
  input logic            i_rst_b,
  spi_reg_ctrl_if.master bus
);

  localparam logic [7:0] TO_LIM = 8'(RD_TIMEOUT);

  typedef enum logic [2:0] {IDLE, WR_DATA, RD_WAIT, RD_HOLD, DONE} state_t;

  state_t     state;
  logic       cs_meta;
  logic       cs_b_s;
  logic [7:0] to_cnt;
  logic       tx_valid;
  logic [7:0] tx_byte;
  logic [1:0] mod_sel;
  logic [4:0] ioc;
  logic       wr_stb;
  logic [7:0] wr_data;
  logic       rd_stb;
  logic [7:0] err_cnt;
  logic       rx_hit;
  logic       to_hit;
  logic [8:0] err_sum;
`ifdef SPI_CTRL_BURST_EN
  logic       wr_first;
`endif

  // Two-flop synchroniser for the raw chip select; reset treats the bus as deselected.
  always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      cs_meta <= 1'b1;
      cs_b_s  <= 1'b1;
    end else begin
      cs_meta <= bus.i_spi_cs_b;
      cs_b_s  <= cs_meta;
    end
  end

  // Error sources while waiting for read data: a stray rx byte and a timeout that lost to no rd_valid.
  always_comb begin
    rx_hit = 1'b0;
    to_hit = 1'b0;
    if (!cs_b_s && state == RD_WAIT) begin
      rx_hit = bus.i_rx_data_valid;
      to_hit = !bus.i_rd_valid && (to_cnt == TO_LIM);
    end
    err_sum = {1'b0, err_cnt} + {8'd0, rx_hit} + {8'd0, to_hit};
  end

  // Frame FSM with registered strobes; a deselected CS overrides everything else.
  always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      state    <= IDLE;
      to_cnt   <= 8'd0;
      tx_valid <= 1'b0;
      tx_byte  <= 8'h00;
      mod_sel  <= 2'd0;
      ioc      <= 5'd0;
      wr_stb   <= 1'b0;
      wr_data  <= 8'h00;
      rd_stb   <= 1'b0;
      err_cnt  <= 8'h00;
`ifdef SPI_CTRL_BURST_EN
      wr_first <= 1'b0;
`endif
    end else begin
      wr_stb   <= 1'b0;
      rd_stb   <= 1'b0;
      tx_valid <= 1'b0;
      err_cnt  <= err_sum[8] ? 8'hFF : err_sum[7:0];
      if (cs_b_s) begin
        state   <= IDLE;
        tx_byte <= 8'h00;
        to_cnt  <= 8'd0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.i_rx_data_valid) begin
              mod_sel <= bus.i_rx_byte[6:5];
              ioc     <= bus.i_rx_byte[4:0];
              if (bus.i_rx_byte[7]) begin
                state <= WR_DATA;
`ifdef SPI_CTRL_BURST_EN
                wr_first <= 1'b1;
`endif
              end else begin
                rd_stb <= 1'b1;
                to_cnt <= 8'd0;
                state  <= RD_WAIT;
              end
            end
          end
          WR_DATA: begin
            if (bus.i_rx_data_valid) begin
              wr_data <= bus.i_rx_byte;
              wr_stb  <= 1'b1;
`ifdef SPI_CTRL_BURST_EN
              // The first data byte goes to the commanded address; later bytes step it.
              wr_first <= 1'b0;
              if (!wr_first) ioc <= ioc + 5'd1;
`else
              state    <= DONE;
              tx_valid <= 1'b1;
              tx_byte  <= 8'h00;
`endif
            end
          end
          RD_WAIT: begin
            if (bus.i_rd_valid) begin
              tx_byte  <= bus.i_rd_data;
              tx_valid <= 1'b1;
              state    <= RD_HOLD;
            end else if (to_hit) begin
              tx_byte  <= 8'hEE;
              tx_valid <= 1'b1;
              state    <= RD_HOLD;
            end else begin
              to_cnt <= to_cnt + 8'd1;
            end
          end
          RD_HOLD: begin
`ifdef SPI_CTRL_BURST_EN
            if (bus.i_rx_data_valid) begin
              ioc    <= ioc + 5'd1;
              rd_stb <= 1'b1;
              to_cnt <= 8'd0;
              state  <= RD_WAIT;
            end
`else
            state    <= DONE;
            tx_valid <= 1'b1;
            tx_byte  <= 8'h00;
`endif
          end
          DONE: begin
            state <= DONE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.o_tx_data_valid = tx_valid;
  assign bus.o_tx_byte       = tx_byte;
  assign bus.o_mod_sel       = mod_sel;
  assign bus.o_ioc           = ioc;
  assign bus.o_wr_stb        = wr_stb;
  assign bus.o_wr_data       = wr_data;
  assign bus.o_rd_stb        = rd_stb;
  assign bus.o_err_cnt       = err_cnt;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Self-checking bench for spi_reg_ctrl against a frame-level reference model.
// Works in both builds; SPI_CTRL_BURST_EN selects the burst expectations.
module tb_spi_reg_ctrl;

  localparam int TO = 15;
`ifdef SPI_CTRL_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_b;
  int   checks = 0;
  int   failures = 0;
  int   exp_err = 0;

  always #5 clk = ~clk;

  spi_reg_ctrl_if bus ();

  spi_reg_ctrl #(.RD_TIMEOUT(TO)) dut (
    .i_sys_clk (clk),
    .i_rst_b   (rst_b),
    .bus       (bus)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic frame_start();
    bus.i_spi_cs_b = 1'b0;
    repeat (3) step();
  endtask

  task automatic frame_end();
    bus.i_spi_cs_b = 1'b1;
    repeat (4) step();
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.i_rx_byte       = b;
    bus.i_rx_data_valid = 1'b1;
    step();
    bus.i_rx_data_valid = 1'b0;
  endtask

  // One write frame: command, data byte, then an extra byte (burst continues, otherwise ignored).
  task automatic run_write(input logic [1:0] mod, input logic [4:0] ioc,
                           input logic [7:0] data, input logic [7:0] extra);
    logic [4:0]  nxt;
    logic [13:0] exp_x;
    nxt = ioc + 5'd1;
    frame_start();
    send_byte({1'b1, mod, ioc});
    checks++;
    if (bus.o_wr_stb !== 1'b0 || bus.o_rd_stb !== 1'b0) begin
      failures++;
      $display("FAIL wr_cmd_quiet: wr_stb=%b rd_stb=%b want 0 0", bus.o_wr_stb, bus.o_rd_stb);
    end
    send_byte(data);
    checks++;
    if ({bus.o_wr_stb, bus.o_mod_sel, bus.o_ioc, bus.o_wr_data} !== {1'b1, mod, ioc, data}) begin
      failures++;
      $display("FAIL wr_strobe: stb=%b mod=%0d ioc=%0d data=%h want 1 %0d %0d %h",
               bus.o_wr_stb, bus.o_mod_sel, bus.o_ioc, bus.o_wr_data, mod, ioc, data);
    end
    checks++;
    if ({bus.o_tx_data_valid, bus.o_tx_byte} !== {!BURST, 8'h00}) begin
      failures++;
      $display("FAIL wr_done_tx: tx_valid=%b tx_byte=%h want %b 00",
               bus.o_tx_data_valid, bus.o_tx_byte, !BURST);
    end
    step();
    checks++;
    if (bus.o_wr_stb !== 1'b0) begin
      failures++;
      $display("FAIL wr_single_cycle: wr_stb=%b want 0", bus.o_wr_stb);
    end
    send_byte(extra);
    exp_x = BURST ? {1'b1, nxt, extra} : {1'b0, ioc, data};
    checks++;
    if ({bus.o_wr_stb, bus.o_ioc, bus.o_wr_data} !== exp_x) begin
      failures++;
      $display("FAIL wr_extra_byte: got %h want %h", {bus.o_wr_stb, bus.o_ioc, bus.o_wr_data}, exp_x);
    end
    frame_end();
  endtask

  // One read frame: rd_valid L cycles after rd_stb (never if L > TO); optional stray byte in the wait.
  task automatic run_read(input logic [1:0] mod, input logic [4:0] ioc, input logic [7:0] data,
                          input int lat, input bit disc);
    int         lret, first_k, second_k, pulses, extra_rd;
    logic [7:0] exp_byte, got_byte, second_byte;
    lret     = (lat <= TO) ? lat : TO;
    exp_byte = (lat <= TO) ? data : 8'hEE;
    if (lat > TO) exp_err = (exp_err < 255) ? exp_err + 1 : 255;
    if (disc)     exp_err = (exp_err < 255) ? exp_err + 1 : 255;
    first_k = -1; second_k = -1; pulses = 0; extra_rd = 0;
    got_byte = 8'h00; second_byte = 8'h00;
    frame_start();
    send_byte({1'b0, mod, ioc});
    checks++;
    if ({bus.o_rd_stb, bus.o_mod_sel, bus.o_ioc} !== {1'b1, mod, ioc}) begin
      failures++;
      $display("FAIL rd_request: stb=%b mod=%0d ioc=%0d want 1 %0d %0d",
               bus.o_rd_stb, bus.o_mod_sel, bus.o_ioc, mod, ioc);
    end
    for (int k = 1; k <= lret + 4; k++) begin
      step();
      bus.i_rd_valid      = 1'b0;
      bus.i_rx_data_valid = 1'b0;
      if (bus.o_rd_stb) extra_rd++;
      if (bus.o_tx_data_valid) begin
        pulses++;
        if (first_k < 0) begin
          first_k  = k;
          got_byte = bus.o_tx_byte;
        end else begin
          second_k    = k;
          second_byte = bus.o_tx_byte;
        end
      end
      if (k == lat && lat <= TO) begin
        bus.i_rd_valid = 1'b1;
        bus.i_rd_data  = data;
      end
      if (k == 1 && disc) begin
        bus.i_rx_byte       = 8'($urandom);
        bus.i_rx_data_valid = 1'b1;
      end
    end
    checks++;
    if (first_k !== lret + 1 || got_byte !== exp_byte) begin
      failures++;
      $display("FAIL rd_return: cycle=%0d byte=%h want cycle=%0d byte=%h (lat=%0d)",
               first_k, got_byte, lret + 1, exp_byte, lat);
    end
    checks++;
    if (pulses !== (BURST ? 1 : 2) || second_k !== (BURST ? -1 : lret + 2) || second_byte !== 8'h00) begin
      failures++;
      $display("FAIL rd_done_tx: pulses=%0d second_cycle=%0d second_byte=%h want %0d %0d 00",
               pulses, second_k, second_byte, BURST ? 1 : 2, BURST ? -1 : lret + 2);
    end
    checks++;
    if (extra_rd !== 0) begin
      failures++;
      $display("FAIL rd_single_stb: extra rd_stb=%0d want 0", extra_rd);
    end
    checks++;
    if (bus.o_err_cnt !== 8'(exp_err)) begin
      failures++;
      $display("FAIL rd_err_cnt: got %0d want %0d (lat=%0d disc=%0d)", bus.o_err_cnt, exp_err, lat, disc);
    end
    frame_end();
  endtask

  task automatic test_reset();
    rst_b = 1'b0;
    bus.i_spi_cs_b = 1'b1; bus.i_rx_data_valid = 1'b0; bus.i_rx_byte = 8'h00;
    bus.i_rd_valid = 1'b0; bus.i_rd_data = 8'h00;
    #3;
    checks++;
    if ({bus.o_tx_data_valid, bus.o_wr_stb, bus.o_rd_stb, bus.o_tx_byte, bus.o_wr_data,
         bus.o_err_cnt, bus.o_mod_sel, bus.o_ioc} !== 34'd0) begin
      failures++;
      $display("FAIL reset_values: tx_v=%b wr=%b rd=%b tx=%h wd=%h err=%h mod=%0d ioc=%0d want all 0",
               bus.o_tx_data_valid, bus.o_wr_stb, bus.o_rd_stb, bus.o_tx_byte, bus.o_wr_data,
               bus.o_err_cnt, bus.o_mod_sel, bus.o_ioc);
    end
    #24 rst_b = 1'b1;
    repeat (3) step();
  endtask

  task automatic test_write();
    run_write(2'd1, 5'd3, 8'h5C, 8'h91);
    for (int i = 0; i < 6; i++)
      run_write(2'($urandom), 5'($urandom), 8'($urandom), 8'($urandom));
  endtask

  task automatic test_read_latency();
    run_read(2'd2, 5'd2, 8'h7E, 4, 1'b0);
  endtask

  task automatic test_timeout();
    run_read(2'd0, 5'd9, 8'h33, 1000, 1'b0);
    run_read(2'd3, 5'd31, 8'hC4, TO, 1'b0);
    run_read(2'd1, 5'd0, 8'h19, TO + 1, 1'b0);
    run_read(2'd1, 5'd1, 8'h20, 1, 1'b1);
  endtask

  task automatic test_read_random();
    for (int i = 0; i < 12; i++)
      run_read(2'($urandom), 5'($urandom), 8'($urandom), int'($urandom_range(1, TO + 3)),
               1'($urandom_range(0, 1)));
  endtask

  task automatic test_burst_wrap();
    logic [7:0] d [3];
    logic [4:0] got_ioc [$];
    logic [7:0] got_dat [$];
    logic [4:0] e_ioc;
    int         n_exp;
    for (int i = 0; i < 3; i++) d[i] = 8'($urandom);
    frame_start();
    send_byte({1'b1, 2'd2, 5'd30});
    for (int i = 0; i < 3; i++) begin
      send_byte(d[i]);
      if (bus.o_wr_stb) begin
        got_ioc.push_back(bus.o_ioc);
        got_dat.push_back(bus.o_wr_data);
      end
    end
    n_exp = BURST ? 3 : 1;
    checks++;
    if (got_ioc.size() !== n_exp) begin
      failures++;
      $display("FAIL burst_count: strobes=%0d want %0d", got_ioc.size(), n_exp);
    end
    for (int i = 0; i < got_ioc.size() && i < n_exp; i++) begin
      e_ioc = 5'((30 + i) % 32);
      checks++;
      if (got_ioc[i] !== e_ioc || got_dat[i] !== d[i]) begin
        failures++;
        $display("FAIL burst_beat%0d: ioc=%0d data=%h want %0d %h", i, got_ioc[i], got_dat[i], e_ioc, d[i]);
      end
    end
    frame_end();
  endtask

  task automatic test_cs_abort();
    int tx_pulses, wr_pulses;
    tx_pulses = 0; wr_pulses = 0;
    frame_start();
    send_byte({1'b0, 2'd3, 5'd17});
    checks++;
    if (bus.o_rd_stb !== 1'b1) begin
      failures++;
      $display("FAIL abort_rd_stb: rd_stb=%b want 1", bus.o_rd_stb);
    end
    repeat (2) step();
    bus.i_spi_cs_b = 1'b1;
    repeat (2) step();
    bus.i_rd_valid = 1'b1;
    bus.i_rd_data  = 8'($urandom_range(1, 255));
    for (int k = 0; k < 12; k++) begin
      step();
      bus.i_rd_valid      = 1'b0;
      bus.i_rx_data_valid = 1'b0;
      if (bus.o_tx_data_valid) tx_pulses++;
      if (bus.o_wr_stb) wr_pulses++;
      if (k == 2) begin bus.i_rx_byte = 8'hA1; bus.i_rx_data_valid = 1'b1; end
      if (k == 3) begin bus.i_rx_byte = 8'h66; bus.i_rx_data_valid = 1'b1; end
    end
    checks++;
    if (tx_pulses !== 0 || bus.o_tx_byte !== 8'h00) begin
      failures++;
      $display("FAIL abort_tx: pulses=%0d tx_byte=%h want 0 00", tx_pulses, bus.o_tx_byte);
    end
    checks++;
    if (wr_pulses !== 0 || bus.o_err_cnt !== 8'(exp_err)) begin
      failures++;
      $display("FAIL abort_quiet: wr_pulses=%0d err=%0d want 0 %0d", wr_pulses, bus.o_err_cnt, exp_err);
    end
    run_write(2'd1, 5'd12, 8'h3D, 8'hB7);
  endtask

  task automatic test_async_reset();
    logic [7:0] d;
    d = 8'($urandom_range(1, 255));
    frame_start();
    send_byte({1'b1, 2'd3, 5'd30});
    send_byte(d);
    checks++;
    if (bus.o_wr_stb !== 1'b1 || bus.o_err_cnt === 8'd0) begin
      failures++;
      $display("FAIL areset_pre: wr_stb=%b err=%0d want 1 nonzero", bus.o_wr_stb, bus.o_err_cnt);
    end
    #2 rst_b = 1'b0;
    #1;
    checks++;
    if ({bus.o_tx_data_valid, bus.o_wr_stb, bus.o_rd_stb, bus.o_tx_byte, bus.o_wr_data,
         bus.o_err_cnt, bus.o_mod_sel, bus.o_ioc} !== 34'd0) begin
      failures++;
      $display("FAIL areset_immediate: wr=%b wd=%h err=%0d mod=%0d ioc=%0d tx_v=%b tx=%h want all 0",
               bus.o_wr_stb, bus.o_wr_data, bus.o_err_cnt, bus.o_mod_sel, bus.o_ioc,
               bus.o_tx_data_valid, bus.o_tx_byte);
    end
    exp_err = 0;
    bus.i_spi_cs_b = 1'b1;
    #13 rst_b = 1'b1;
    repeat (3) step();
    run_write(2'd2, 5'd31, 8'hE1, 8'h0F);
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_latency();
    test_timeout();
    test_read_random();
    test_burst_wrap();
    test_cs_abort();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_reg_ctrl.md
# spi_reg_ctrl

Register-access protocol controller between the SPI slave byte interface and the FPGA's internal module register bus. It parses each chip-select frame as a command byte followed by data bytes. It issues write or read strobes to one of four target modules, and loads read-back bytes into the SPI slave's transmit path. Everything runs in the `i_sys_clk` domain. Only the raw `i_spi_cs_b` is synchronised internally.

## Interface
- `RD_TIMEOUT`, default 15: cycles to wait for `i_rd_valid` after `o_rd_stb`; range 1–255.
- `i_sys_clk` in 1: system clock.
- `i_rst_b` in 1: asynchronous, active-low reset.
- `i_spi_cs_b` in 1: raw SPI chip select; 2-FF synchronised to `cs_b_s` inside the block.
- `i_rx_data_valid` in 1: one-cycle pulse, received byte available.
- `i_rx_byte` in 8: received byte.
- `o_tx_data_valid` out 1: one-cycle pulse; SPI slave reloads its tx byte from `o_tx_byte`.
- `o_tx_byte` out 8: next byte to shift out on MISO.
- `o_mod_sel` out 2: target module index.
- `o_ioc` out 5: register address within the module.
- `o_wr_stb` out 1: one-cycle write strobe.
- `o_wr_data` out 8: write data.
- `o_rd_stb` out 1: one-cycle read request.
- `i_rd_valid` in 1: read data valid; may be asserted from the cycle after `o_rd_stb` onward.
- `i_rd_data` in 8: read data, sampled when `i_rd_valid` is high.
- `o_err_cnt` out 8: saturating error counter.

## Operation
- **Command byte:**
  - bit7 = 1 write, 0 read.
  - bits[6:5] = `o_mod_sel`.
  - bits[4:0] = `o_ioc`.
- **States:**
  - IDLE
    - On `i_rx_data_valid`, latch the command fields.
    - Write command → WR_DATA.
    - Read command → pulse `o_rd_stb` and go to RD_WAIT.
  - WR_DATA
    - On `i_rx_data_valid`: `o_wr_data` = byte, pulse `o_wr_stb`.
    - With burst: stay in WR_DATA, `o_ioc` += 1.
    - Without burst: → DONE.
  - RD_WAIT
    - On `i_rd_valid`: `o_tx_byte` = `i_rd_data`, pulse `o_tx_data_valid`, → RD_HOLD.
    - On timeout: `o_tx_byte` = 0xEE, pulse `o_tx_data_valid`, increment `o_err_cnt`, → RD_HOLD.
    - A byte received here is discarded and increments `o_err_cnt`.
  - RD_HOLD
    - With burst, on `i_rx_data_valid`: `o_ioc` += 1, pulse `o_rd_stb`, → RD_WAIT.
    - Without burst: → DONE.
  - DONE
    - Ignore all bytes.
    - `o_tx_byte` = 0x00; pulse `o_tx_data_valid` once on entry.
- **`cs_b_s` high in any state:**
  - Next state is IDLE; all strobes 0.
  - `o_tx_byte` = 0x00; the timeout counter clears.
  - Takes priority over any same-cycle `i_rx_data_valid`, `i_rd_valid` or timeout.
- **Address increment:** wraps modulo 32 (31 → 0); `o_mod_sel` never changes within a frame.
- **`o_err_cnt`:** saturates at 255; cleared only by reset.

## Timing
- **Reset values:**
  - All strobes and `o_tx_data_valid` = 0.
  - `o_tx_byte`, `o_wr_data`, `o_err_cnt` = 0x00.
  - `o_ioc` = 0, `o_mod_sel` = 0; state IDLE.
- **Registered outputs:** all outputs are registered, with no combinational path from inputs.
- **Write:** data-byte `i_rx_data_valid` at cycle T → `o_wr_stb`, `o_wr_data`, `o_ioc`, `o_mod_sel` valid at T+1.
- **Read request:** command-byte valid at T → `o_rd_stb` at T+1, with address stable from T+1 until the next request.
- **Read return:** `i_rd_valid` at cycle R → `o_tx_data_valid` and `o_tx_byte` at R+1.
- **Timeout:**
  - The counter starts at the `o_rd_stb` cycle.
  - Timeout fires when the count reaches `RD_TIMEOUT` with no `i_rd_valid`.
  - `o_tx_data_valid` at `o_rd_stb` + `RD_TIMEOUT` + 1.
  - `i_rd_valid` on the same cycle as the timeout wins: data is returned, no error.
- **Frame end:** CS deassertion takes effect 2 cycles after the `i_spi_cs_b` edge; worst-case frame-end latency is 3 cycles.

## Configuration
- Macro `SPI_CTRL_BURST_EN`.
- **Defined:**
  - Multi-byte bursts with auto-incrementing `o_ioc`.
  - Read burst: each received byte triggers the next read, with data for address N+1 loaded during byte N+1.
- **Undefined:**
  - Exactly one data byte per frame; the controller enters DONE afterwards.
  - No `o_ioc` increment logic is built.

## Test plan
- **Single write:** write 0xA3 (module 1, ioc 3), then 0x5C → one `o_wr_stb` with `o_mod_sel`=1, `o_ioc`=3, `o_wr_data`=0x5C, one cycle after the data valid.
- **Read with latency 4:** read 0x42, `i_rd_valid` 4 cycles after `o_rd_stb` with data 0x7E → `o_tx_data_valid` with 0x7E one cycle later; `o_err_cnt` unchanged.
- **Read timeout:** `i_rd_valid` never asserted, `RD_TIMEOUT`=15 → `o_tx_byte`=0xEE at `o_rd_stb`+16; `o_err_cnt` increments by 1.
- **Burst wrap (`SPI_CTRL_BURST_EN`):** write ioc 30 with 3 data bytes → `o_ioc` sequence 30, 31, 0. Same frame without the macro → one strobe only.
- **CS abort:** deassert CS in RD_WAIT with `i_rd_valid` arriving on the CS-sync cycle → state IDLE, `o_tx_data_valid` not pulsed, `o_tx_byte`=0x00.
- **Async reset:** assert `i_rst_b`=0 mid-burst → all outputs are at their reset values immediately, without waiting for a clock edge.
